// File: rtl/core_boot_ctrl.sv
// core_boot_ctrl: releases the RISC-V core from reset once the host sets the
// run DIP. It watches the to-host mailbox for a pass/fail word, counts run
// cycles, enforces a timeout, and serves the BAR1 register window.
module core_boot_ctrl #(
   parameter int unsigned RST_HOLD_CYCLES = 16,
   parameter logic [11:0] TOHOST_OFFSET   = 12'h120,
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1_000_000
) (
   input  logic        clk_main_a0,
   input  logic        rst_main,
   input  logic        vdip_run,
   input  logic        host_wr_valid,
   input  logic [11:0] host_wr_addr,
   input  logic [31:0] host_wr_data,
   output logic        host_wr_ready,
   input  logic        host_rd_valid,
   input  logic [11:0] host_rd_addr,
   output logic        host_rd_ready,
   output logic        host_rd_data_valid,
   output logic [31:0] host_rd_data,
   input  logic        core_tohost_we,
   input  logic [31:0] core_tohost_data,
   output logic        core_rst,
   output logic [15:0] vled
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HOLD = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_TOUT = 3'd4
   } state_t;

   localparam logic [11:0] ADDR_TOHOST  = TOHOST_OFFSET;
   localparam logic [11:0] ADDR_STATUS  = TOHOST_OFFSET + 12'h4;
   localparam logic [11:0] ADDR_CYCLES  = TOHOST_OFFSET + 12'h8;
   localparam logic [11:0] ADDR_TIMEOUT = TOHOST_OFFSET + 12'hC;
   localparam logic [31:0] BAD_READ     = 32'hDEAD_0BAD;
   // The counter counts down to zero inclusive, so load one less than the hold length.
   localparam logic [31:0] HOLD_LOAD    = 32'(RST_HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] hold_cnt_q, hold_cnt_d;
   logic [31:0] cycles_q, cycles_d;
   logic [31:0] tohost_q, tohost_d;
   logic [31:0] timeout_q, timeout_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic        core_rst_q, core_rst_d;
   logic        wr_ready_q, wr_ready_d;
   logic        rd_ready_q, rd_ready_d;
   logic        rd_data_valid_q, rd_data_valid_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic [11:0] rd_addr_q, rd_addr_d;
   logic        core_wr;
   logic [31:0] rd_mux;

   // Cycle counter must stick at all-ones rather than wrap.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Boot sequencing: next state, hold countdown, cycle count and verdict bits.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      cycles_d   = cycles_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      case (state_q)
         ST_IDLE: begin
            if (vdip_run) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_LOAD;
               cycles_d   = 32'd0;
               pass_d     = 1'b0;
               fail_d     = 1'b0;
            end
         end
         ST_HOLD: begin
            if (!vdip_run) begin
               state_d = ST_IDLE;
            end else if (hold_cnt_q == 32'd0) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q - 32'd1;
            end
         end
         ST_RUN: begin
            // A core verdict outranks a timeout landing on the same cycle;
            // the count only advances while the core stays in RUN.
            if (!vdip_run) begin
               state_d = ST_IDLE;
            end else if (core_tohost_we) begin
               state_d = ST_DONE;
               pass_d  = (core_tohost_data == 32'd0);
               fail_d  = (core_tohost_data != 32'd0);
            end else if (cycles_q == timeout_q) begin
               state_d = ST_TOUT;
            end else begin
               cycles_d = sat_inc(cycles_q);
            end
         end
         ST_DONE, ST_TOUT: begin
            if (!vdip_run) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered so core_rst drops on the same edge that enters RUN.
      core_rst_d = (state_d != ST_RUN);
   end

   // Host register window: one-cycle ready pulses, core writes beat host writes.
   always_comb begin
      wr_ready_d = host_wr_valid & ~wr_ready_q;
      rd_ready_d = host_rd_valid & ~rd_ready_q;
      rd_addr_d  = rd_ready_d ? host_rd_addr : rd_addr_q;
      core_wr    = core_tohost_we & (state_q == ST_RUN);
      tohost_d   = tohost_q;
      timeout_d  = timeout_q;
      if (core_wr) begin
         tohost_d = core_tohost_data;
      end else if (wr_ready_d && (host_wr_addr == ADDR_TOHOST)) begin
         tohost_d = host_wr_data;
      end
      if (wr_ready_d && (host_wr_addr == ADDR_TIMEOUT)) begin
         timeout_d = host_wr_data;
      end
      case (rd_addr_q)
         ADDR_TOHOST:  rd_mux = tohost_q;
         ADDR_STATUS:  rd_mux = {27'd0, fail_q, pass_q, state_q};
         ADDR_CYCLES:  rd_mux = cycles_q;
         ADDR_TIMEOUT: rd_mux = timeout_q;
         default:      rd_mux = BAD_READ;
      endcase
      // Data is returned the cycle after the ready pulse and held afterwards.
      rd_data_valid_d = rd_ready_q;
      rd_data_d       = rd_ready_q ? rd_mux : rd_data_q;
   end

   // State and register update with synchronous reset of everything.
   always_ff @(posedge clk_main_a0) begin
      if (rst_main) begin
         state_q         <= ST_IDLE;
         hold_cnt_q      <= 32'd0;
         cycles_q        <= 32'd0;
         tohost_q        <= 32'd0;
         timeout_q       <= TIMEOUT_DEFAULT;
         pass_q          <= 1'b0;
         fail_q          <= 1'b0;
         core_rst_q      <= 1'b1;
         wr_ready_q      <= 1'b0;
         rd_ready_q      <= 1'b0;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= 32'd0;
         rd_addr_q       <= 12'd0;
      end else begin
         state_q         <= state_d;
         hold_cnt_q      <= hold_cnt_d;
         cycles_q        <= cycles_d;
         tohost_q        <= tohost_d;
         timeout_q       <= timeout_d;
         pass_q          <= pass_d;
         fail_q          <= fail_d;
         core_rst_q      <= core_rst_d;
         wr_ready_q      <= wr_ready_d;
         rd_ready_q      <= rd_ready_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_q       <= rd_data_d;
         rd_addr_q       <= rd_addr_d;
      end
   end

   assign host_wr_ready      = wr_ready_q;
   assign host_rd_ready      = rd_ready_q;
   assign host_rd_data_valid = rd_data_valid_q;
   assign host_rd_data       = rd_data_q;
   assign core_rst           = core_rst_q;
   assign vled               = {10'd0, ~core_rst_q, fail_q, pass_q, state_q};

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Testbench for core_boot_ctrl: randomized boot runs checked against a
// behavioural model of the register window and run verdicts.
module tb_core_boot_ctrl;

   localparam int          HOLD   = 16;
   localparam logic [11:0] OFF    = 12'h120;
   localparam logic [31:0] TO_DEF = 32'd1_000_000;

   logic        clk = 1'b0;
   logic        rst_main = 1'b1;
   logic        vdip_run = 1'b0;
   logic        host_wr_valid = 1'b0;
   logic [11:0] host_wr_addr = 12'd0;
   logic [31:0] host_wr_data = 32'd0;
   logic        host_wr_ready;
   logic        host_rd_valid = 1'b0;
   logic [11:0] host_rd_addr = 12'd0;
   logic        host_rd_ready;
   logic        host_rd_data_valid;
   logic [31:0] host_rd_data;
   logic        core_tohost_we = 1'b0;
   logic [31:0] core_tohost_data = 32'd0;
   logic        core_rst;
   logic [15:0] vled;

   int checks = 0;
   int errors = 0;

   // Behavioural model: register contents and run verdict.
   logic [31:0] m_tohost, m_timeout, m_cycles;
   logic [2:0]  m_state;
   logic        m_pass, m_fail;

   always #5 clk = ~clk;

   core_boot_ctrl dut (
      .clk_main_a0(clk), .rst_main(rst_main), .vdip_run(vdip_run),
      .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
      .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
      .host_rd_valid(host_rd_valid), .host_rd_addr(host_rd_addr),
      .host_rd_ready(host_rd_ready), .host_rd_data_valid(host_rd_data_valid),
      .host_rd_data(host_rd_data), .core_tohost_we(core_tohost_we),
      .core_tohost_data(core_tohost_data), .core_rst(core_rst), .vled(vled)
   );

   function automatic logic [15:0] m_vled();
      return {10'd0, (m_state == 3'd2), m_fail, m_pass, m_state};
   endfunction

   function automatic logic [31:0] m_status();
      return {27'd0, m_fail, m_pass, m_state};
   endfunction

   function automatic logic [31:0] m_reg(input logic [11:0] a);
      if (a == OFF)               return m_tohost;
      else if (a == OFF + 12'h4)  return m_status();
      else if (a == OFF + 12'h8)  return m_cycles;
      else if (a == OFF + 12'hC)  return m_timeout;
      else                        return 32'hDEAD_0BAD;
   endfunction

   task automatic host_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = d;
      @(negedge clk);
      host_wr_valid = 1'b0;
      checks++;
      if (host_wr_ready !== 1'b1) begin
         errors++; $display("FAIL wr_ready addr=%h got=%b exp=1", a, host_wr_ready);
      end
      if (a == OFF) m_tohost = d;
      else if (a == OFF + 12'hC) m_timeout = d;
   endtask

   task automatic host_read(input logic [11:0] a, output logic [31:0] d);
      bit got;
      @(negedge clk);
      host_rd_valid = 1'b1; host_rd_addr = a;
      @(negedge clk);
      host_rd_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (host_rd_data_valid === 1'b1) begin got = 1'b1; break; end
      end
      d = host_rd_data;
      checks++;
      if (!got) begin
         errors++; $display("FAIL rd_timeout addr=%h got=no data_valid exp=data_valid", a);
      end
   endtask

   task automatic start_run(output int edges);
      @(negedge clk);
      vdip_run = 1'b1;
      edges = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         edges++;
         if (core_rst === 1'b0) break;
      end
      m_state = 3'd2; m_cycles = 32'd0; m_pass = 1'b0; m_fail = 1'b0;
   endtask

   task automatic end_run();
      @(negedge clk);
      vdip_run = 1'b0;
      @(negedge clk);
      m_state = 3'd0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_main = 1'b1;
      repeat (3) @(negedge clk);
      rst_main = 1'b0;
      m_tohost = 32'd0; m_timeout = TO_DEF; m_cycles = 32'd0;
      m_state = 3'd0; m_pass = 1'b0; m_fail = 1'b0;
      checks++;
      if ({core_rst, host_wr_ready, host_rd_ready, host_rd_data_valid} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=1000",
                            {core_rst, host_wr_ready, host_rd_ready, host_rd_data_valid});
      end
      checks++;
      if (vled !== 16'd0 || host_rd_data !== 32'd0) begin
         errors++; $display("FAIL reset_out vled=%h rd_data=%h exp=0/0", vled, host_rd_data);
      end
      for (int r = 0; r < 4; r++) begin
         host_read(OFF + 12'(4 * r), d);
         checks++;
         if (d !== m_reg(OFF + 12'(4 * r))) begin
            errors++; $display("FAIL reset_reg%0d got=%h exp=%h", r, d, m_reg(OFF + 12'(4 * r)));
         end
      end
   endtask

   task automatic test_pass();
      int e, n;
      logic [31:0] d;
      for (int it = 0; it < 2; it++) begin
         n = (it == 0) ? 100 : int'($urandom_range(300, 1));
         host_write(OFF, (it == 0) ? 32'hDEADBEEF : $urandom);
         start_run(e);
         checks++;
         if (e != HOLD + 1) begin
            errors++; $display("FAIL pass_hold_edges got=%0d exp=%0d", e, HOLD + 1);
         end
         repeat (n) @(negedge clk);
         core_tohost_we = 1'b1; core_tohost_data = 32'd0;
         @(negedge clk);
         core_tohost_we = 1'b0;
         m_state = 3'd3; m_pass = 1'b1; m_cycles = 32'(n); m_tohost = 32'd0;
         checks++;
         if (core_rst !== 1'b1 || vled !== m_vled()) begin
            errors++; $display("FAIL pass_vled core_rst=%b vled=%h exp=1/%h", core_rst, vled, m_vled());
         end
         for (int r = 0; r < 3; r++) begin
            host_read(OFF + 12'(4 * r), d);
            checks++;
            if (d !== m_reg(OFF + 12'(4 * r))) begin
               errors++; $display("FAIL pass_reg%0d got=%h exp=%h", r, d, m_reg(OFF + 12'(4 * r)));
            end
         end
         end_run();
         checks++;
         if (vled !== m_vled()) begin
            errors++; $display("FAIL pass_sticky_idle vled=%h exp=%h", vled, m_vled());
         end
      end
   endtask

   task automatic test_fail();
      int e, n;
      logic [31:0] d, v;
      for (int it = 0; it < 2; it++) begin
         v = (it == 0) ? 32'h3 : $urandom;
         if (v == 32'd0) v = 32'h8000_0000;
         n = int'($urandom_range(120, 1));
         host_write(OFF, $urandom);
         start_run(e);
         repeat (n) @(negedge clk);
         core_tohost_we = 1'b1; core_tohost_data = v;
         @(negedge clk);
         core_tohost_we = 1'b0;
         m_state = 3'd3; m_fail = 1'b1; m_cycles = 32'(n); m_tohost = v;
         checks++;
         if (core_rst !== 1'b1) begin
            errors++; $display("FAIL fail_core_rst got=%b exp=1", core_rst);
         end
         for (int r = 0; r < 3; r++) begin
            host_read(OFF + 12'(4 * r), d);
            checks++;
            if (d !== m_reg(OFF + 12'(4 * r))) begin
               errors++; $display("FAIL fail_reg%0d got=%h exp=%h", r, d, m_reg(OFF + 12'(4 * r)));
            end
         end
         end_run();
         checks++;
         if (vled !== m_vled()) begin
            errors++; $display("FAIL fail_sticky_idle vled=%h exp=%h", vled, m_vled());
         end
      end
   endtask

   task automatic test_timeout();
      int e, t;
      logic [31:0] d;
      for (int it = 0; it < 3; it++) begin
         t = (it == 0) ? 50 : (it == 1) ? 0 : int'($urandom_range(80, 1));
         host_write(OFF + 12'hC, 32'(t));
         start_run(e);
         repeat (t) @(negedge clk);
         checks++;
         if (core_rst !== 1'b0) begin
            errors++; $display("FAIL tout_early t=%0d core_rst=%b exp=0", t, core_rst);
         end
         @(negedge clk);
         m_state = 3'd4; m_cycles = 32'(t);
         checks++;
         if (core_rst !== 1'b1 || vled !== m_vled()) begin
            errors++; $display("FAIL tout_enter t=%0d core_rst=%b vled=%h exp=1/%h", t, core_rst, vled, m_vled());
         end
         host_read(OFF + 12'h8, d);
         checks++;
         if (d !== m_cycles) begin
            errors++; $display("FAIL tout_cycles got=%h exp=%h", d, m_cycles);
         end
         host_read(OFF + 12'h4, d);
         checks++;
         if (d !== m_status()) begin
            errors++; $display("FAIL tout_status got=%h exp=%h", d, m_status());
         end
         end_run();
      end
      host_write(OFF + 12'hC, TO_DEF);
   endtask

   task automatic test_collision();
      int e, readies;
      logic [31:0] d;
      start_run(e);
      repeat (3) @(negedge clk);
      @(negedge clk);
      host_wr_valid = 1'b1; host_wr_addr = OFF; host_wr_data = 32'h1234;
      core_tohost_we = 1'b1; core_tohost_data = 32'd0;
      @(negedge clk);
      host_wr_valid = 1'b0; core_tohost_we = 1'b0;
      readies = int'(host_wr_ready);
      repeat (3) begin
         @(negedge clk);
         readies += int'(host_wr_ready);
      end
      m_state = 3'd3; m_pass = 1'b1; m_tohost = 32'd0;
      checks++;
      if (readies != 1) begin
         errors++; $display("FAIL coll_ready_pulses got=%0d exp=1", readies);
      end
      host_read(OFF, d);
      checks++;
      if (d !== m_tohost) begin
         errors++; $display("FAIL coll_tohost got=%h exp=%h", d, m_tohost);
      end
      end_run();
   endtask

   task automatic test_abort();
      int w;
      logic [31:0] d;
      w = int'($urandom_range(40, 5));
      @(negedge clk);
      vdip_run = 1'b1;
      @(negedge clk);
      m_state = 3'd1; m_pass = 1'b0; m_fail = 1'b0; m_cycles = 32'd0;
      checks++;
      if (vled !== m_vled()) begin
         errors++; $display("FAIL abort_hold_clear vled=%h exp=%h", vled, m_vled());
      end
      for (int i = 0; i < 40; i++) begin
         if (core_rst === 1'b0) break;
         @(negedge clk);
      end
      repeat (w) @(negedge clk);
      vdip_run = 1'b0;
      @(negedge clk);
      m_state = 3'd0; m_cycles = 32'(w);
      checks++;
      if (core_rst !== 1'b1 || vled !== m_vled()) begin
         errors++; $display("FAIL abort_idle core_rst=%b vled=%h exp=1/%h", core_rst, vled, m_vled());
      end
      host_read(OFF + 12'h8, d);
      checks++;
      if (d !== m_cycles) begin
         errors++; $display("FAIL abort_cycles got=%h exp=%h", d, m_cycles);
      end
      @(negedge clk);
      vdip_run = 1'b1;
      @(negedge clk);
      m_state = 3'd1; m_cycles = 32'd0;
      host_read(OFF + 12'h8, d);
      checks++;
      if (d !== m_cycles) begin
         errors++; $display("FAIL restart_cycles got=%h exp=%h", d, m_cycles);
      end
      host_read(OFF + 12'h4, d);
      checks++;
      if (d !== m_status()) begin
         errors++; $display("FAIL restart_status got=%h exp=%h", d, m_status());
      end
      end_run();
   endtask

   task automatic test_reads();
      logic [31:0] d;
      logic [11:0] a;
      int readies;
      @(negedge clk);
      host_rd_valid = 1'b1; host_rd_addr = 12'h130;
      @(negedge clk);
      host_rd_valid = 1'b0;
      checks++;
      if (host_rd_ready !== 1'b1 || host_rd_data_valid !== 1'b0) begin
         errors++; $display("FAIL rd_lat1 ready=%b dv=%b exp=1/0", host_rd_ready, host_rd_data_valid);
      end
      @(negedge clk);
      checks++;
      if (host_rd_data_valid !== 1'b1 || host_rd_data !== 32'hDEAD_0BAD) begin
         errors++; $display("FAIL rd_lat2 dv=%b data=%h exp=1/dead0bad", host_rd_data_valid, host_rd_data);
      end
      @(negedge clk);
      checks++;
      if (host_rd_data_valid !== 1'b0) begin
         errors++; $display("FAIL rd_dv_pulse got=%b exp=0", host_rd_data_valid);
      end
      // held valid: one acceptance per ready pulse
      @(negedge clk);
      host_rd_valid = 1'b1; host_rd_addr = OFF;
      readies = 0;
      repeat (4) begin
         @(negedge clk);
         readies += int'(host_rd_ready);
      end
      host_rd_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (readies != 2) begin
         errors++; $display("FAIL rd_held_pulses got=%0d exp=2", readies);
      end
      for (int i = 0; i < 4; i++) begin
         a = 12'($urandom_range(4095, 0));
         if (a >= OFF && a <= OFF + 12'hC && a[1:0] == 2'b00) a = 12'h200;
         host_write(a, $urandom);
         host_write(OFF + 12'hC, $urandom);
         host_read(a, d);
         checks++;
         if (d !== m_reg(a)) begin
            errors++; $display("FAIL rd_bad_off addr=%h got=%h exp=%h", a, d, m_reg(a));
         end
         host_read(OFF + 12'hC, d);
         checks++;
         if (d !== m_timeout) begin
            errors++; $display("FAIL rd_timeout_rw got=%h exp=%h", d, m_timeout);
         end
         host_read(OFF, d);
         checks++;
         if (d !== m_tohost) begin
            errors++; $display("FAIL rd_tohost_kept got=%h exp=%h", d, m_tohost);
         end
      end
      host_write(OFF + 12'hC, TO_DEF);
   endtask

   task automatic test_rst_in_run();
      int e;
      logic [31:0] d;
      host_write(OFF, $urandom | 32'h1);
      start_run(e);
      repeat (10) @(negedge clk);
      rst_main = 1'b1; vdip_run = 1'b0;
      @(negedge clk);
      checks++;
      if (core_rst !== 1'b1 || vled !== 16'd0 || host_rd_data !== 32'd0) begin
         errors++; $display("FAIL rst_run_out core_rst=%b vled=%h rd_data=%h exp=1/0/0",
                            core_rst, vled, host_rd_data);
      end
      rst_main = 1'b0;
      m_tohost = 32'd0; m_timeout = TO_DEF; m_cycles = 32'd0;
      m_state = 3'd0; m_pass = 1'b0; m_fail = 1'b0;
      for (int r = 0; r < 4; r++) begin
         host_read(OFF + 12'(4 * r), d);
         checks++;
         if (d !== m_reg(OFF + 12'(4 * r))) begin
            errors++; $display("FAIL rst_run_reg%0d got=%h exp=%h", r, d, m_reg(OFF + 12'(4 * r)));
         end
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_collision();
      test_abort();
      test_reads();
      test_rst_in_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_boot_ctrl.md
Name: core_boot_ctrl

Overview:
Downstream consumer of the host program-load sequence: after the host loads the program image into DDR over DMA PCIS, it seeds the to-host mailbox over BAR1 and sets virtual DIP bit 0. This block then releases the RISC-V core from reset and monitors the to-host mailbox for completion. It owns the to-host and status registers on the BAR1 register window, counts run cycles, enforces a timeout and drives status LEDs.

Parameters:
RST_HOLD_CYCLES, 16, cycles core_rst stays high after run is requested
TOHOST_OFFSET, 12'h120, BAR1 byte offset of the TOHOST register
TIMEOUT_DEFAULT, 32'd1_000_000, reset value of the TIMEOUT register

Ports:
clk_main_a0  in  1  main clock
rst_main  in  1  synchronous, active-high reset
vdip_run  in  1  virtual DIP bit 0; 1 = run core
host_wr_valid  in  1  BAR1 write request
host_wr_addr  in  12  byte offset
host_wr_data  in  32  write data
host_wr_ready  out  1  write accepted
host_rd_valid  in  1  BAR1 read request
host_rd_addr  in  12  byte offset
host_rd_ready  out  1  read accepted
host_rd_data_valid  out  1  read data strobe
host_rd_data  out  32  read data
core_tohost_we  in  1  core writes the to-host word
core_tohost_data  in  32  core to-host value
core_rst  out  1  core reset, active high
vled  out  16  status LEDs

Behaviour:
- Register map, offsets relative to TOHOST_OFFSET:
  - +0 TOHOST: RW.
  - +4 STATUS: RO. bits[2:0] = state code; bit3 = pass; bit4 = fail.
  - +8 CYCLES: RO, 32-bit.
  - +C TIMEOUT: RW.
  - Other offsets: writes ignored, reads return 32'hDEAD_0BAD.
- Reset values: core_rst=1; host_wr_ready=0; host_rd_ready=0; host_rd_data_valid=0; host_rd_data=0; vled=0; TOHOST=0; CYCLES=0; TIMEOUT=TIMEOUT_DEFAULT; state=IDLE.
- Host handshake:
  - host_wr_ready and host_rd_ready pulse for 1 cycle, in the cycle after their valid is sampled.
  - Read data is returned with host_rd_data_valid 1 cycle after the ready pulse, i.e. 2-cycle latency.
  - Only one outstanding read at a time. A valid held high is accepted once per ready pulse.
- States (code):
  - IDLE (0): core_rst=1, CYCLES frozen. On vdip_run=1: clear CYCLES, load hold counter, go to HOLD.
  - HOLD (1): core_rst=1; decrement hold counter. At 0, go to RUN; core_rst drops on the same edge.
  - RUN (2): core_rst=0; CYCLES increments every cycle, saturating at 32'hFFFF_FFFF.
    - core_tohost_we with data==0: go to DONE, set pass.
    - core_tohost_we with data!=0: go to DONE, set fail.
    - CYCLES==TIMEOUT with no core write: go to TOUT.
  - DONE (3) / TOUT (4): core_rst=1, CYCLES frozen. Stay until vdip_run=0, then go to IDLE; pass/fail stay sticky until the next IDLE->HOLD transition.
  - vdip_run=0 in HOLD or RUN: go to IDLE on the next edge, core_rst=1, pass/fail unchanged.
- TOHOST write rules:
  - Core writes are honoured only in RUN.
  - Same-cycle core write and host write to TOHOST: the core write wins and the host write is dropped, but still acknowledged with host_wr_ready.
- TIMEOUT=0: a timeout on the first RUN cycle.
- Host writes to TIMEOUT during RUN take effect on the next cycle's compare.
- vled: [2:0]=state code, [3]=pass, [4]=fail, [5]=~core_rst, [15:6]=0.
- rst_main asserted in any state: all registers and outputs return to their reset values on the next edge. core_rst is held high throughout.

Test Plan:
- Run with pass: rst, host writes TOHOST=32'hDEADBEEF, vdip_run=1 → core_rst falls exactly RST_HOLD_CYCLES+1 edges later. After 100 RUN cycles the core writes 0 → STATUS reads state=3, pass=1; TOHOST reads 0; CYCLES reads 100; vled[3]=1.
- Run with fail: the core writes 32'h0000_0003 → STATUS fail=1, pass=0, TOHOST=3, core_rst=1.
- Timeout: TIMEOUT=50, run with no core write → state=4 after 50 RUN cycles, CYCLES=50, core_rst=1.
- Same-cycle collision: host writes TOHOST=32'h1234 in the same cycle as a core write of 0 → TOHOST=0, host_wr_ready pulses once.
- Abort and restart: drop vdip_run mid-RUN → IDLE next cycle, core_rst=1. Re-raise vdip_run → CYCLES cleared, pass/fail cleared, HOLD re-entered.
- Reads: read from offset 0x130 → 32'hDEAD_0BAD, host_rd_data_valid 2 cycles after host_rd_valid. rst_main pulsed in RUN → all reset values restored.
